fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end for the 32-bit pipelined core. It holds the architectural PC, drives instruction-memory requests over a valid/ready handshake, and presents fetched instructions to decode in a one-entry output register. Decode and execute compute branch, jump, jr and bex targets; this block consumes the resulting redirect. It flushes wrong-path fetches, including a memory response still in flight.

## Interface
- RESET_PC, 12'd0, PC loaded on reset.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- imem_req  out  1  request valid; address in imem_addr.
- imem_addr  out  12  word address of request.
- imem_ready  in  1  memory accepts and completes the request this cycle; imem_rdata valid.
- imem_rdata  in  32  instruction word, sampled only when imem_req && imem_ready.
- redirect  in  1  one-cycle pulse: the next-PC logic selected a non-sequential target.
- redirect_pc  in  12  target PC, valid with redirect.
- id_ready  in  1  decode accepts id_* this cycle.
- id_valid  out  1  id_* holds a valid instruction.
- id_pc  out  12  PC of id_insn.
- id_pc_plus1  out  12  id_pc + 1, mod 4096.
- id_insn  out  32  fetched instruction.

## Operation
- Registers: pc[11:0], output register {id_valid, id_pc, id_pc_plus1, id_insn}, and a 2-bit state: BOOT, FETCH, DRAIN.
- BOOT is entered on reset. imem_req = 0. The block goes to FETCH on the next edge.
- FETCH:
  - imem_req = (!id_valid || id_ready) and imem_addr = pc.
  - On imem_req && imem_ready with no redirect, the output register loads {1, pc, pc+1, imem_rdata}. pc becomes pc+1, wrapping 4095 to 0.
- Consumption: id_valid && id_ready with no new load clears id_valid. A load in the same cycle overwrites the register, giving back-to-back throughput.
- Request stability: once imem_req is asserted without imem_ready, imem_req and imem_addr stay constant until imem_ready. This holds by construction, because a request with a full output register can only arise when id_ready = 1, so id_valid is 0 on the next cycle.
- Redirect. In any state, redirect = 1 does the following:
  - pc becomes redirect_pc and id_valid becomes 0 on the next edge. This overrides any load or consume in the same cycle.
  - If imem_req = 1 and imem_ready = 0 that cycle, the next state is DRAIN. Otherwise the next state is FETCH.
  - If imem_req && imem_ready that cycle, the returned data is discarded.
- DRAIN:
  - imem_req = 1, and imem_addr holds the abandoned address in a dedicated drain_addr register.
  - On imem_ready the data is discarded and the next state is FETCH.
  - A further redirect during DRAIN updates pc only. The block stays in DRAIN until imem_ready.
- BOOT + redirect: pc takes redirect_pc and the next state is FETCH.
- Reset asserted mid-operation forces all state immediately, with no handshake completion. A memory response in flight is the memory's responsibility.
- Arithmetic is 12-bit unsigned with silent wrap. There is no misalignment concept, because addresses are word indices.

## Timing
- Reset values:
  - imem_req = 0, imem_addr = RESET_PC.
  - id_valid = 0, id_pc = 0, id_pc_plus1 = 0, id_insn = 0.
  - pc = RESET_PC, state = BOOT.
- First request appears in the first cycle after reset deasserts plus one (BOOT cycle).
- Latency: a request accepted in cycle N (imem_ready = 1) gives id_valid = 1 in cycle N+1.
- Zero-wait memory with id_ready held at 1 gives one instruction per cycle.
- imem_ready = 0 for k cycles stretches the request by k cycles with no bubble beyond k.
- Redirect in cycle N, with no outstanding request, puts imem_addr = redirect_pc in cycle N+1. The first target instruction is id_valid in cycle N+2 at the earliest.
- Redirect with an outstanding request takes drain cycles plus one before the target request.
- id_* outputs change only on a load, consume or redirect. They are stable while id_valid && !id_ready.
- imem_req and imem_addr are combinational from registered state and id_valid/id_ready, never from imem_ready. There is no combinational path from imem_ready to imem_req.

## Test plan
- Reset RESET_PC = 12'h010, zero-wait memory, id_ready = 1. Expect imem_addr 0x010, 0x011, 0x012 on consecutive cycles and id_pc one cycle later each, with id_pc_plus1 = id_pc + 1.
- Wrap: redirect_pc = 12'hFFF, then run. Expect id_pc 0xFFF with id_pc_plus1 0x000, then the next id_pc = 0x000.
- Backpressure: hold id_ready = 0 for 5 cycles with id_valid = 1. Expect imem_req = 0, id_* frozen and pc unchanged. After release, the next instruction arrives with no loss or duplicate.
- Redirect during a 3-cycle wait: request addr 0x020, redirect to 0x100 in wait cycle 1. Expect imem_addr held at 0x020 until imem_ready, the data not presented (id_valid stays 0), then a request at 0x100.
- Redirect coinciding with imem_ready for addr 0x030 and id_ready = 1, to 0x200. Expect the 0x030 data dropped, id_valid = 0 next cycle, and the next imem_addr = 0x200.
- Async reset asserted mid-wait (imem_req = 1). Expect imem_req = 0 and id_valid = 0 immediately, and state BOOT when reset releases.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end; holds the PC, drives imem
// requests and presents fetched words to decode in a one-entry register.
//
// Ports:
//   clock, reset (async, active-low)
//   imem_req/imem_addr  -> request; imem_ready/imem_rdata <- completion
//   redirect/redirect_pc -> non-sequential target from next-PC logic
//   id_ready <- decode accepts; id_valid/id_pc/id_pc_plus1/id_insn -> decode
module fetch_unit #(
  parameter logic [11:0] RESET_PC = 12'd0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [11:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [11:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [11:0] id_pc,
  output logic [11:0] id_pc_plus1,
  output logic [31:0] id_insn
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [11:0] pc;
  logic [11:0] drain_addr;
  logic        fire;
  logic        stall_req;
  logic        consume;

  // A request with a full output register only exists when decode is
  // draining it this cycle, so the request stays stable across waits.
  assign imem_req = (state == DRAIN) ||
                    ((state == FETCH) && (!id_valid || id_ready));

  assign imem_addr = (state == DRAIN) ? drain_addr : pc;

  assign fire      = imem_req && imem_ready;
  assign stall_req = imem_req && !imem_ready;
  assign consume   = id_valid && id_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      drain_addr  <= RESET_PC;
      id_valid    <= 1'b0;
      id_pc       <= 12'd0;
      id_pc_plus1 <= 12'd0;
      id_insn     <= 32'd0;
    end else begin
      unique case (state)
        BOOT: begin
          state <= FETCH;
          if (redirect) begin
            pc       <= redirect_pc;
            id_valid <= 1'b0;
          end
        end
        FETCH: begin
          if (redirect) begin
            pc       <= redirect_pc;
            id_valid <= 1'b0;
            // The abandoned request must still be completed before the
            // target can be issued; remember where it was going.
            if (stall_req) begin
              state      <= DRAIN;
              drain_addr <= pc;
            end
          end else if (fire) begin
            id_valid    <= 1'b1;
            id_pc       <= pc;
            id_pc_plus1 <= pc + 12'd1;
            id_insn     <= imem_rdata;
            pc          <= pc + 12'd1;
          end else if (consume) begin
            id_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (redirect) begin
            pc       <= redirect_pc;
            id_valid <= 1'b0;
          end
          if (imem_ready) begin
            state <= FETCH;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test of fetch_unit against a transaction-level
// model, plus hand-computed literal expectations.
module tb_fetch_unit;

  localparam logic [11:0] RPC = 12'h010;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = 12'd0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [11:0] id_pc;
  logic [11:0] id_pc_plus1;
  logic [31:0] id_insn;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_pc_plus1 (id_pc_plus1),
    .id_insn     (id_insn)
  );

  function automatic logic [31:0] mem(input logic [11:0] a);
    return {4'hA, a, 4'h5, a};
  endfunction

  assign imem_rdata = mem(imem_addr);

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the block is booting, draining an abandoned request, or
  // fetching; output register is a simple record.
  bit          m_boot  = 1'b1;
  bit          m_drain = 1'b0;
  logic [11:0] m_daddr = RPC;
  logic [11:0] m_pc    = RPC;
  bit          m_ov    = 1'b0;
  logic [11:0] m_opc   = 12'd0;
  logic [11:0] m_onext = 12'd0;
  logic [31:0] m_oins  = 32'd0;

  function automatic bit m_req(input bit idr);
    if (m_boot) return 1'b0;
    if (m_drain) return 1'b1;
    return !m_ov || idr;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_boot  = 1'b1;
      m_drain = 1'b0;
      m_pc    = RPC;
      m_ov    = 1'b0;
      m_opc   = 12'd0;
      m_onext = 12'd0;
      m_oins  = 32'd0;
    end else if (m_boot) begin
      m_boot = 1'b0;
      if (redirect) m_pc = redirect_pc;
    end else if (m_drain) begin
      if (redirect) m_pc = redirect_pc;
      if (imem_ready) m_drain = 1'b0;
    end else begin
      bit req;
      req = m_req(id_ready);
      if (redirect) begin
        m_ov = 1'b0;
        if (req && !imem_ready) begin
          m_drain = 1'b1;
          m_daddr = m_pc;
        end
        m_pc = redirect_pc;
      end else if (req && imem_ready) begin
        m_ov    = 1'b1;
        m_opc   = m_pc;
        m_onext = (m_pc + 12'd1) % 4096;
        m_oins  = mem(m_pc);
        m_pc    = (m_pc + 12'd1) % 4096;
      end else if (m_ov && id_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    check("imem_req", {31'd0, imem_req}, {31'd0, m_req(id_ready)});
    if (m_req(id_ready))
      check("imem_addr", {20'd0, imem_addr},
            {20'd0, m_drain ? m_daddr : m_pc});
    check("id_valid", {31'd0, id_valid}, {31'd0, m_ov});
    check("id_pc", {20'd0, id_pc}, {20'd0, m_opc});
    check("id_pc_plus1", {20'd0, id_pc_plus1}, {20'd0, m_onext});
    check("id_insn", id_insn, m_oins);
  end

  task automatic step(input bit rd, input logic [11:0] rpc,
                      input bit rdy, input bit idr);
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = rdy;
    id_ready    = idr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #2;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", {20'd0, imem_addr}, 32'h010);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_insn", id_insn, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("boot_req", {31'd0, imem_req}, 32'd1);
    check("boot_addr", {20'd0, imem_addr}, 32'h010);

    // zero-wait streaming
    step(0, 12'h0, 1, 1);
    check("s0_pc", {20'd0, id_pc}, 32'h010);
    check("s0_p1", {20'd0, id_pc_plus1}, 32'h011);
    check("s0_insn", id_insn, 32'hA0105010);
    check("s0_addr", {20'd0, imem_addr}, 32'h011);
    step(0, 12'h0, 1, 1);
    check("s1_pc", {20'd0, id_pc}, 32'h011);
    step(0, 12'h0, 1, 1);
    check("s2_pc", {20'd0, id_pc}, 32'h012);
    check("s2_addr", {20'd0, imem_addr}, 32'h013);

    // wrap
    step(1, 12'hFFF, 1, 1);
    check("w_valid", {31'd0, id_valid}, 32'd0);
    check("w_addr", {20'd0, imem_addr}, 32'hFFF);
    step(0, 12'h0, 1, 1);
    check("w_pc", {20'd0, id_pc}, 32'hFFF);
    check("w_p1", {20'd0, id_pc_plus1}, 32'h000);
    step(0, 12'h0, 1, 1);
    check("w_pc2", {20'd0, id_pc}, 32'h000);
    check("w_p12", {20'd0, id_pc_plus1}, 32'h001);

    // backpressure
    for (int i = 0; i < 5; i++) begin
      step(0, 12'h0, 1, 0);
      check("bp_req", {31'd0, imem_req}, 32'd0);
      check("bp_pc", {20'd0, id_pc}, 32'h000);
    end
    check("bp_valid", {31'd0, id_valid}, 32'd1);
    step(0, 12'h0, 1, 1);
    check("bp_next", {20'd0, id_pc}, 32'h001);
    check("bp_insn", id_insn, 32'hA0015001);

    // redirect during a 3-cycle wait
    step(1, 12'h020, 1, 1);
    check("d_addr0", {20'd0, imem_addr}, 32'h020);
    step(0, 12'h0, 0, 1);
    step(1, 12'h100, 0, 1);
    check("d_addr1", {20'd0, imem_addr}, 32'h020);
    check("d_req1", {31'd0, imem_req}, 32'd1);
    step(0, 12'h0, 0, 1);
    check("d_addr2", {20'd0, imem_addr}, 32'h020);
    check("d_valid", {31'd0, id_valid}, 32'd0);
    step(0, 12'h0, 1, 1);
    check("d_valid2", {31'd0, id_valid}, 32'd0);
    check("d_tgt", {20'd0, imem_addr}, 32'h100);
    step(0, 12'h0, 1, 1);
    check("d_pc", {20'd0, id_pc}, 32'h100);
    check("d_insn", id_insn, 32'hA1005100);

    // redirect coinciding with imem_ready
    step(1, 12'h030, 1, 1);
    step(1, 12'h200, 1, 1);
    check("c_valid", {31'd0, id_valid}, 32'd0);
    check("c_addr", {20'd0, imem_addr}, 32'h200);
    step(0, 12'h0, 1, 1);
    check("c_pc", {20'd0, id_pc}, 32'h200);

    // second redirect while draining updates pc only
    step(0, 12'h0, 0, 1);
    step(1, 12'h300, 0, 1);
    check("dd_addr", {20'd0, imem_addr}, 32'h201);
    step(1, 12'h340, 0, 1);
    check("dd_addr2", {20'd0, imem_addr}, 32'h201);
    step(0, 12'h0, 1, 1);
    check("dd_tgt", {20'd0, imem_addr}, 32'h340);

    // async reset mid-wait
    step(0, 12'h0, 0, 1);
    check("ar_req0", {31'd0, imem_req}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_req", {31'd0, imem_req}, 32'd0);
    check("ar_valid", {31'd0, id_valid}, 32'd0);
    check("ar_addr", {20'd0, imem_addr}, 32'h010);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("ar_boot", {31'd0, imem_req}, 32'd0);

    // redirect during BOOT
    step(1, 12'h050, 1, 1);
    check("br_addr", {20'd0, imem_addr}, 32'h050);
    check("br_req", {31'd0, imem_req}, 32'd1);
    step(0, 12'h0, 1, 1);
    check("br_pc", {20'd0, id_pc}, 32'h050);
    step(0, 12'h0, 1, 1);
    @(negedge clock);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
